mp_add_seq: RTL and testbench



---
 rtl/mp_add_seq.sv | 147 ++++++++++++++
 tb/tb_mp_add_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - multi-precision sequential adder driving one fan slice per cycle

// fan: N_BITS-wide ripple-carry adder slice
module fan #(
    parameter int N_BITS = 4
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic              cin,
    output logic [N_BITS-1:0] sum,
    output logic              cout
);

    logic [N_BITS:0] w_carry;

    // Bit-serial carry chain through full adders
    always_comb begin
        w_carry    = '0;
        sum        = '0;
        w_carry[0] = cin;
        for (int i = 0; i < N_BITS; i++) begin
            sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            w_carry[i+1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
        end
        cout = w_carry[N_BITS];
    end

endmodule

// mp_add_seq: accepts wide operands, adds them chunk by chunk, presents registered result
module mp_add_seq #(
    parameter  int N_BITS = 4,
    parameter  int WORDS  = 4,
    localparam int W      = N_BITS * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [W-1:0]       r_sum;
    logic               r_cout;

    logic [N_BITS-1:0]  w_a_chunk;
    logic [N_BITS-1:0]  w_b_chunk;
    logic [N_BITS-1:0]  w_chunk_sum;
    logic               w_chunk_cout;
    logic               w_last;

    assign w_a_chunk = r_a[r_idx*N_BITS +: N_BITS];
    assign w_b_chunk = r_b[r_idx*N_BITS +: N_BITS];
    assign w_last    = (r_idx == LAST_IDX);

    fan #(.N_BITS(N_BITS)) u_fan (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .cin  (r_carry),
        .sum  (w_chunk_sum),
        .cout (w_chunk_cout)
    );

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: accept in IDLE, walk chunks in RUN, hold result in DONE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next_state = S_RUN;
            S_RUN:   if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // Datapath: capture operands, then fold one chunk sum and carry per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx*N_BITS +: N_BITS] <= w_chunk_sum;
                    r_carry                       <= w_chunk_cout;
                    if (w_last) begin
                        r_cout <= w_chunk_cout;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and status flags come from registered state only
    assign in_ready  = (r_state == S_IDLE) & ~rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_mp_add_seq.sv
// tb/tb_mp_add_seq.sv - directed self-checking bench for mp_add_seq
module tb_mp_add_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        iv0, ir0, c0, ov0, or0, co0, bz0;
    logic [15:0] a0, b0, s0;

    logic        iv1, ir1, c1, ov1, or1, co1, bz1;
    logic [7:0]  a1, b1, s1;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    int pulses;
    logic bz_acc;

    always #5 clk = ~clk;

    mp_add_seq #(.N_BITS(4), .WORDS(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(c0),
        .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0), .busy(bz0)
    );

    mp_add_seq #(.N_BITS(8), .WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .busy(bz1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_ov(input int sel);
        return (sel == 0) ? ov0 : ov1;
    endfunction

    // Called just after a falling edge; returns cycles from accept to out_valid
    task automatic run_op(input int sel, input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic inject, output int l, output logic bz);
        if (sel == 0) begin
            iv0 = 1'b1; a0 = va; b0 = vb; c0 = vc;
        end else begin
            iv1 = 1'b1; a1 = va[7:0]; b1 = vb[7:0]; c1 = vc;
        end
        @(negedge clk);
        bz = (sel == 0) ? bz0 : bz1;
        if (sel == 0) begin
            iv0 = inject; a0 = 16'h1111; b0 = 16'h1111; c0 = 1'b1;
        end else begin
            iv1 = 1'b0;
        end
        l = 0;
        while (!cur_ov(sel) && l < 20) begin
            @(negedge clk);
            l++;
            iv0 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        iv0 = 0; a0 = 0; b0 = 0; c0 = 0; or0 = 1'b1;
        iv1 = 0; a1 = 0; b1 = 0; c1 = 0; or1 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  ir0, 1'b0);
        check("rst_out_valid", ov0, 1'b0);
        check("rst_sum",       s0,  16'h0);
        check("rst_cout",      co0, 1'b0);
        check("rst_busy",      bz0, 1'b0);
        check("rst_in_ready1", ir1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready",  ir0, 1'b1);
        check("post_rst_in_ready1", ir1, 1'b1);

        // Carry ripples through every chunk
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bz_acc);
        check("ripple_busy", bz_acc, 1'b1);
        check("ripple_lat",  lat, 4);
        check("ripple_sum",  s0,  16'h0000);
        check("ripple_cout", co0, 1'b1);
        @(negedge clk);
        check("ripple_ov_drop",  ov0, 1'b0);
        check("ripple_in_ready", ir0, 1'b1);

        // Carry-in, no overflow
        run_op(0, 16'h1234, 16'h4321, 1'b1, 1'b0, lat, bz_acc);
        check("cin_lat",  lat, 4);
        check("cin_sum",  s0,  16'h5556);
        check("cin_cout", co0, 1'b0);
        @(negedge clk);

        // Back-pressure holds the result
        or0 = 1'b0;
        run_op(0, 16'h8000, 16'h8000, 1'b0, 1'b0, lat, bz_acc);
        check("bp_lat", lat, 4);
        for (int i = 0; i < 5; i++) begin
            check("bp_ov",       ov0, 1'b1);
            check("bp_sum",      s0,  16'h0000);
            check("bp_cout",     co0, 1'b1);
            check("bp_in_ready", ir0, 1'b0);
            if (i < 4) @(negedge clk);
        end
        or0 = 1'b1;
        @(negedge clk);
        check("bp_release_ov", ov0, 1'b0);
        check("bp_release_ir", ir0, 1'b1);

        // in_valid during RUN is ignored
        run_op(0, 16'h0F0F, 16'h00F1, 1'b0, 1'b1, lat, bz_acc);
        check("ign_lat",  lat, 4);
        check("ign_sum",  s0,  16'h1000);
        check("ign_cout", co0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("ign_no_capture_busy", bz0, 1'b0);
            check("ign_no_capture_ov",   ov0, 1'b0);
            @(negedge clk);
        end

        // Reset in the cycle after chunk 1
        iv0 = 1'b1; a0 = 16'h2222; b0 = 16'h1111; c0 = 1'b0;
        @(negedge clk);
        iv0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_partial_sum", s0, 16'h1033);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ov",   ov0, 1'b0);
        check("mid_rst_sum",  s0,  16'h0);
        check("mid_rst_cout", co0, 1'b0);
        check("mid_rst_busy", bz0, 1'b0);
        check("mid_rst_ir",   ir0, 1'b0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov0) pulses++;
        end
        check("mid_rst_no_pulse", pulses, 0);
        check("mid_rst_idle",     bz0, 1'b0);
        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, lat, bz_acc);
        check("fresh_lat",  lat, 4);
        check("fresh_sum",  s0,  16'h0002);
        check("fresh_cout", co0, 1'b0);
        @(negedge clk);

        // Single-chunk configuration
        run_op(1, 16'h00FF, 16'h0001, 1'b1, 1'b0, lat, bz_acc);
        check("w1_busy", bz_acc, 1'b1);
        check("w1_lat",  lat, 1);
        check("w1_sum",  s1,  8'h01);
        check("w1_cout", co1, 1'b1);
        @(negedge clk);
        check("w1_ov_drop",  ov1, 1'b0);
        check("w1_in_ready", ir1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
